ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM pipeline register sitting directly downstream of the ALU. Captures ALU_DC/ALU_Zero/ALU_OverFlow
//  with the instruction's control bits, resolves BEQ/BNE, raises the signed-overflow exception (ADD/SUB)
//  and holds off EX until the exception is acknowledged. Feeds the MEM stage and the EX forwarding path.
// PARAMETERS
//  DATA_W    32     datapath width (ALU result, PC, store data)
//  REG_AW    5      register-file address width
//  EXC_OV    5'd12  cause code reported for arithmetic overflow
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  rst            in   1       synchronous, active-high reset
//  ex_valid       in   1       EX holds a real instruction this cycle
//  ex_ready       out  1       stage accepts EX this cycle (= !mem_stall && state==RUN)
//  ex_pc          in   DATA_W  PC of the EX instruction
//  ALU_DC         in   DATA_W  ALU result
//  ALU_Zero       in   1       ALU result == 0
//  ALU_OverFlow   in   1       ALU signed overflow (ADD/SUB funcs)
//  ex_ov_trap     in   1       instruction traps on overflow (ADD/SUB, not ADDU/SUBU)
//  ex_store_data  in   DATA_W  rt value for SW
//  ex_rd          in   REG_AW  destination register
//  ex_reg_write, ex_mem_read, ex_mem_write  in 1 each  control bits
//  ex_branch      in   2       00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none)
//  ex_br_target   in   DATA_W  branch target address
//  mem_stall      in   1       MEM cannot accept; stage holds
//  flush          in   1       kill the instruction being captured this cycle
//  exc_ack        in   1       exception handler accepted exc_req
//  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  out 1 each
//  mem_alu_result out  DATA_W  registered ALU_DC
//  mem_store_data out  DATA_W  registered store data
//  mem_rd         out  REG_AW  registered destination
//  br_taken       out  1       one-cycle redirect pulse (registered)
//  br_target      out  DATA_W  redirect address, valid with br_taken
//  exc_req        out  1       overflow exception pending (level until exc_ack)
//  exc_epc        out  DATA_W  PC of faulting instruction
//  exc_cause      out  5       EXC_OV while exc_req
// BEHAVIOUR
//  Reset: all outputs 0; state=RUN; all registered data 0.
//  Latency: 1 cycle EX->MEM. Capture when ex_ready; fire = ex_valid && ex_ready && !flush.
//  mem_stall=1: all mem_* regs hold; br_taken forced 0; no capture; EX must hold its inputs.
//  Not stalled, no fire: mem_valid<=0, mem_reg_write/mem_mem_read/mem_mem_write<=0 (bubble); data regs don't-care.
//  fire, no trap: copy all fields; mem_valid<=1.
//  Branch: taken = (BEQ && ALU_Zero) || (BNE && !ALU_Zero); br_taken<=fire&&taken for exactly one cycle;
//   br_target<=ex_br_target. Branch instrs never write regs or memory regardless of control inputs.
//  Trap = fire && ex_ov_trap && ALU_OverFlow: insert bubble (no reg/mem write), exc_epc<=ex_pc,
//   exc_cause<=EXC_OV, exc_req<=1, state<=TRAP_WAIT. ALU_OverFlow ignored when ex_ov_trap=0.
//  FSM: RUN -(trap)-> TRAP_WAIT -(exc_ack)-> RUN. In TRAP_WAIT: ex_ready=0, bubbles issued downstream,
//   exc_req=1, exc_epc/exc_cause held. exc_ack: exc_req<=0 next cycle, state<=RUN. exc_ack in RUN ignored.
//  flush and trap same cycle: flush wins (no exception). flush in TRAP_WAIT: no effect on pending exception.
//  rst mid-TRAP_WAIT or mid-stall: returns to reset values next edge, pending exception discarded.
//  ALU result passed unmodified, full DATA_W, no sign/zero extension here.
// STRUCTURE
//  Shared package mips_pkg: branch encodings (BR_NONE/BEQ/BNE), exception cause codes (EXC_OV=12),
//   FSM state enum (ST_RUN, ST_TRAP_WAIT). Single module; no sub-module needed.
// TESTING
//  ADD 0x7FFFFFFF+1, ex_ov_trap=1 -> mem_valid=0, exc_req=1, exc_epc=ex_pc, exc_cause=12, ex_ready=0 until exc_ack.
//  ADDU same operands (ex_ov_trap=0), rd=8 -> mem_alu_result=0x80000000, mem_reg_write=1, exc_req=0.
//  BEQ with ALU_Zero=1, target 0x00400020 -> br_taken=1 for 1 cycle, br_target=0x00400020; BNE same -> br_taken=0.
//  mem_stall=1 for 3 cycles after capturing LW rd=9 -> mem_* constant, ex_ready=0, br_taken=0 throughout.
//  flush together with overflow trap -> bubble, exc_req stays 0, state RUN.
//  rst asserted during TRAP_WAIT -> next cycle exc_req=0, ex_ready=1, all mem_* = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch encodings, exception cause codes,
// and the EX/MEM control FSM states.
package mips_pkg;

  // Branch field encodings carried with the EX instruction
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // Exception cause codes
  localparam logic [4:0] EXC_OV  = 5'd12;

  // EX/MEM stage control states
  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_TRAP_WAIT = 1'b1
  } ex_state_e;

  // Branch resolution from the encoded branch type and the ALU zero flag.
  // The reserved encoding resolves as not-taken.
  function automatic logic br_resolve(input logic [1:0] br, input logic zero);
    logic taken;
    case (br)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the ALU outputs with the instruction's
// control bits, resolves BEQ/BNE into a one-cycle redirect pulse, and raises
// the signed-overflow exception, holding EX off until it is acknowledged.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         REG_AW = 5,
  parameter logic [4:0] EXC_OV = mips_pkg::EXC_OV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ALU_DC,
  input  logic              ALU_Zero,
  input  logic              ALU_OverFlow,
  input  logic              ex_ov_trap,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_branch,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              exc_req,
  output logic [DATA_W-1:0] exc_epc,
  output logic [4:0]        exc_cause
);

  ex_state_e state_r;
  ex_state_e state_nxt_s;

  logic fire_s;       // EX instruction accepted and not killed
  logic trap_s;       // accepted instruction overflowed and must trap
  logic capture_s;    // accepted instruction proceeds to MEM
  logic is_branch_s;  // BEQ/BNE: never writes registers or memory
  logic taken_s;      // branch condition satisfied
  logic ack_s;        // handler acknowledges a pending exception

  // EX may hand over only when MEM can move and no exception is pending
  assign ex_ready = !mem_stall && (state_r == ST_RUN);

  // Qualify the incoming instruction and decode branch/trap conditions
  always_comb begin
    fire_s      = 1'b0;
    trap_s      = 1'b0;
    capture_s   = 1'b0;
    is_branch_s = 1'b0;
    taken_s     = 1'b0;
    ack_s       = 1'b0;

    fire_s    = ex_valid && ex_ready && !flush;
    trap_s    = fire_s && ex_ov_trap && ALU_OverFlow;
    capture_s = fire_s && !trap_s;
    taken_s   = br_resolve(ex_branch, ALU_Zero);
    ack_s     = (state_r == ST_TRAP_WAIT) && exc_ack;

    case (ex_branch)
      BR_BEQ:  is_branch_s = 1'b1;
      BR_BNE:  is_branch_s = 1'b1;
      default: is_branch_s = 1'b0;
    endcase
  end

  // Next-state logic: an overflow trap parks the stage until acknowledged
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (trap_s) begin
          state_nxt_s = ST_TRAP_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_TRAP_WAIT: begin
        if (exc_ack) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_TRAP_WAIT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // EX->MEM pipeline register: hold on stall, bubble when nothing is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      br_taken       <= 1'b0;
      br_target      <= '0;
    end else if (mem_stall) begin
      // MEM keeps its instruction; a redirect must not repeat while frozen
      br_taken <= 1'b0;
    end else begin
      mem_valid     <= capture_s;
      mem_reg_write <= capture_s && !is_branch_s && ex_reg_write;
      mem_mem_read  <= capture_s && !is_branch_s && ex_mem_read;
      mem_mem_write <= capture_s && !is_branch_s && ex_mem_write;
      br_taken      <= capture_s && taken_s;
      if (capture_s) begin
        mem_alu_result <= ALU_DC;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
        br_target      <= ex_br_target;
      end
    end
  end

  // Exception reporting: set on trap, cleared by acknowledge, else held
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_req   <= 1'b0;
      exc_epc   <= '0;
      exc_cause <= 5'd0;
    end else if (trap_s) begin
      exc_req   <= 1'b1;
      exc_epc   <= ex_pc;
      exc_cause <= EXC_OV;
    end else if (ack_s) begin
      exc_req   <= 1'b0;
      exc_cause <= 5'd0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a directed vector table covering the
// documented scenarios, then randomized traffic against a behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready, ALU_Zero, ALU_OverFlow, ex_ov_trap;
  logic [31:0] ex_pc, ALU_DC, ex_store_data, ex_br_target;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_branch;
  logic        mem_stall, flush, exc_ack;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_result, mem_store_data, br_target, exc_epc;
  logic [4:0]  mem_rd, exc_cause;
  logic        br_taken, exc_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ALU_DC(ALU_DC), .ALU_Zero(ALU_Zero), .ALU_OverFlow(ALU_OverFlow),
    .ex_ov_trap(ex_ov_trap), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_br_target(ex_br_target), .mem_stall(mem_stall),
    .flush(flush), .exc_ack(exc_ack), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .br_taken(br_taken),
    .br_target(br_target), .exc_req(exc_req), .exc_epc(exc_epc), .exc_cause(exc_cause)
  );

  typedef struct packed {
    logic        rst, valid, stall, flush, ack, ov_trap, ov, zero, rw, mr, mw;
    logic [1:0]  br;
    logic [31:0] pc, alu, tgt;
    logic [4:0]  rd;
    logic        chk_ready, e_ready;
    logic        e_valid, e_rw, e_mr, e_mw, e_br, e_exc;
    logic [31:0] e_alu, e_epc, e_tgt;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    v.chk_ready = 1'b1;
    v.e_ready   = 1'b1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; ex_valid = v.valid; mem_stall = v.stall; flush = v.flush;
    exc_ack = v.ack; ex_ov_trap = v.ov_trap; ALU_OverFlow = v.ov; ALU_Zero = v.zero;
    ex_reg_write = v.rw; ex_mem_read = v.mr; ex_mem_write = v.mw; ex_branch = v.br;
    ex_pc = v.pc; ALU_DC = v.alu; ex_br_target = v.tgt; ex_rd = v.rd;
    ex_store_data = v.alu ^ 32'h5A5A_0000;
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_pend, m_valid, m_rw, m_mr, m_mw, m_br, m_exc;
  logic [31:0] m_alu, m_sd, m_tgt, m_epc;
  logic [4:0]  m_rd;

  function automatic logic model_ready();
    return !mem_stall && !m_pend;
  endfunction

  task automatic model_step();
    logic accept, overflow, good, is_br, taken;
    if (rst) begin
      {m_pend, m_valid, m_rw, m_mr, m_mw, m_br, m_exc} = 7'd0;
      m_alu = 32'd0; m_sd = 32'd0; m_tgt = 32'd0; m_epc = 32'd0; m_rd = 5'd0;
    end else begin
      accept   = ex_valid && model_ready() && !flush;
      overflow = accept && ex_ov_trap && ALU_OverFlow;
      if (m_pend && exc_ack) begin
        m_pend = 1'b0;
        m_exc  = 1'b0;
      end
      if (mem_stall) begin
        m_br = 1'b0;
      end else begin
        good  = accept && !overflow;
        is_br = (ex_branch == 2'd1) || (ex_branch == 2'd2);
        taken = (ex_branch == 2'd1 && ALU_Zero) || (ex_branch == 2'd2 && !ALU_Zero);
        m_valid = good;
        m_rw    = good && !is_br && ex_reg_write;
        m_mr    = good && !is_br && ex_mem_read;
        m_mw    = good && !is_br && ex_mem_write;
        m_br    = good && taken;
        if (good) begin
          m_alu = ALU_DC; m_sd = ex_store_data; m_rd = ex_rd;
        end
        if (good && taken) m_tgt = ex_br_target;
        if (overflow) begin
          m_pend = 1'b1; m_exc = 1'b1; m_epc = ex_pc;
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    logic exp_ready;

    // ---------------- directed table ----------------
    v = nop(); v.rst = 1'b1; v.chk_ready = 1'b0; tbl.push_back(v);
    // ADD 0x7FFFFFFF+1 with trap enabled
    v = nop(); v.valid = 1'b1; v.ov_trap = 1'b1; v.ov = 1'b1; v.rw = 1'b1; v.rd = 5'd8;
    v.pc = 32'h0040_0000; v.alu = 32'h8000_0000; v.e_exc = 1'b1; v.e_epc = 32'h0040_0000;
    tbl.push_back(v);
    // EX holds the instruction; stage refuses it while the exception is pending
    v.e_ready = 1'b0; tbl.push_back(v); tbl.push_back(v);
    v = nop(); v.ack = 1'b1; v.e_ready = 1'b0; tbl.push_back(v);
    // ADDU same operands: no trap, result written
    v = nop(); v.valid = 1'b1; v.ov = 1'b1; v.rw = 1'b1; v.rd = 5'd8; v.alu = 32'h8000_0000;
    v.e_valid = 1'b1; v.e_rw = 1'b1; v.e_rd = 5'd8; v.e_alu = 32'h8000_0000; tbl.push_back(v);
    // BEQ taken (control write bit must be suppressed)
    v = nop(); v.valid = 1'b1; v.br = 2'd1; v.zero = 1'b1; v.rw = 1'b1; v.tgt = 32'h0040_0020;
    v.e_valid = 1'b1; v.e_br = 1'b1; v.e_tgt = 32'h0040_0020; tbl.push_back(v);
    // BNE with zero set: not taken, pulse drops
    v.br = 2'd2; v.e_br = 1'b0; tbl.push_back(v);
    // BEQ taken then a bubble: pulse lasts one cycle
    v.br = 2'd1; v.e_br = 1'b1; tbl.push_back(v);
    v = nop(); tbl.push_back(v);
    // LW rd=9 then three stalled cycles with different EX contents
    v = nop(); v.valid = 1'b1; v.mr = 1'b1; v.rw = 1'b1; v.rd = 5'd9; v.alu = 32'h1001_0004;
    v.e_valid = 1'b1; v.e_rw = 1'b1; v.e_mr = 1'b1; v.e_rd = 5'd9; v.e_alu = 32'h1001_0004;
    tbl.push_back(v);
    v.stall = 1'b1; v.e_ready = 1'b0; v.alu = 32'hDEAD_BEEF; v.rd = 5'd3; v.br = 2'd1;
    v.zero = 1'b1; v.mw = 1'b1;
    tbl.push_back(v); tbl.push_back(v); tbl.push_back(v);
    v = nop(); tbl.push_back(v);
    // flush with overflow trap: flush wins
    v = nop(); v.valid = 1'b1; v.flush = 1'b1; v.ov_trap = 1'b1; v.ov = 1'b1; v.rw = 1'b1;
    v.pc = 32'h0040_0040; tbl.push_back(v);
    // exc_ack in RUN is ignored
    v = nop(); v.ack = 1'b1; tbl.push_back(v);
    // trap, flush while waiting, then reset during TRAP_WAIT
    v = nop(); v.valid = 1'b1; v.ov_trap = 1'b1; v.ov = 1'b1; v.pc = 32'h0040_0100;
    v.e_exc = 1'b1; v.e_epc = 32'h0040_0100; tbl.push_back(v);
    v.flush = 1'b1; v.e_ready = 1'b0; tbl.push_back(v);
    v = nop(); v.rst = 1'b1; v.valid = 1'b1; v.e_ready = 1'b0; tbl.push_back(v);
    v = nop(); tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply(v);
      #1;
      if (v.chk_ready) check($sformatf("v%0d ex_ready", i), {31'd0, ex_ready}, {31'd0, v.e_ready});
      @(posedge clk); #1;
      check($sformatf("v%0d mem_valid", i), {31'd0, mem_valid}, {31'd0, v.e_valid});
      check($sformatf("v%0d mem_reg_write", i), {31'd0, mem_reg_write}, {31'd0, v.e_rw});
      check($sformatf("v%0d mem_mem_read", i), {31'd0, mem_mem_read}, {31'd0, v.e_mr});
      check($sformatf("v%0d mem_mem_write", i), {31'd0, mem_mem_write}, {31'd0, v.e_mw});
      check($sformatf("v%0d br_taken", i), {31'd0, br_taken}, {31'd0, v.e_br});
      check($sformatf("v%0d exc_req", i), {31'd0, exc_req}, {31'd0, v.e_exc});
      if (v.e_valid) begin
        check($sformatf("v%0d mem_alu_result", i), mem_alu_result, v.e_alu);
        check($sformatf("v%0d mem_rd", i), {27'd0, mem_rd}, {27'd0, v.e_rd});
      end
      if (v.e_br) check($sformatf("v%0d br_target", i), br_target, v.e_tgt);
      if (v.e_exc) begin
        check($sformatf("v%0d exc_epc", i), exc_epc, v.e_epc);
        check($sformatf("v%0d exc_cause", i), {27'd0, exc_cause}, 32'd12);
      end
      if (v.rst) begin
        check($sformatf("v%0d rst alu", i), mem_alu_result, 32'd0);
        check($sformatf("v%0d rst epc", i), exc_epc, 32'd0);
        check($sformatf("v%0d rst cause", i), {27'd0, exc_cause}, 32'd0);
      end
    end

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 500; n++) begin
      rst           = (n == 0) || ($urandom_range(0, 49) == 0);
      ex_valid      = $urandom_range(0, 3) != 0;
      mem_stall     = $urandom_range(0, 3) == 0;
      flush         = $urandom_range(0, 7) == 0;
      exc_ack       = $urandom_range(0, 2) == 0;
      ex_ov_trap    = $urandom_range(0, 1) == 1;
      ALU_OverFlow  = $urandom_range(0, 2) == 0;
      ALU_Zero      = $urandom_range(0, 1) == 1;
      ex_reg_write  = $urandom_range(0, 1) == 1;
      ex_mem_read   = $urandom_range(0, 1) == 1;
      ex_mem_write  = $urandom_range(0, 1) == 1;
      ex_branch     = 2'($urandom_range(0, 3));
      ex_pc         = $urandom;
      ALU_DC        = $urandom;
      ex_store_data = $urandom;
      ex_br_target  = $urandom;
      ex_rd         = 5'($urandom_range(0, 31));
      #1;
      if (n != 0 && !rst) begin
        exp_ready = model_ready();
        check("rnd ex_ready", {31'd0, ex_ready}, {31'd0, exp_ready});
      end
      model_step();
      @(posedge clk); #1;
      check("rnd mem_valid", {31'd0, mem_valid}, {31'd0, m_valid});
      check("rnd ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, {29'd0, m_rw, m_mr, m_mw});
      check("rnd br_taken", {31'd0, br_taken}, {31'd0, m_br});
      check("rnd exc_req", {31'd0, exc_req}, {31'd0, m_exc});
      if (m_valid) begin
        check("rnd mem_alu_result", mem_alu_result, m_alu);
        check("rnd mem_store_data", mem_store_data, m_sd);
        check("rnd mem_rd", {27'd0, mem_rd}, {27'd0, m_rd});
      end
      if (m_br) check("rnd br_target", br_target, m_tgt);
      if (m_exc) begin
        check("rnd exc_epc", exc_epc, m_epc);
        check("rnd exc_cause", {27'd0, exc_cause}, 32'd12);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
